ifetch_prefetch_buffer: RTL

Instruction-fetch front end between the instruction ROM and the IF/ID pipeline register of the 5-stage RV32 core. It owns the fetch PC. It issues word requests to a latency-tolerant IROM port and buffers returned instructions, tagged with their PC, in a small in-order queue. It delivers them to ID under a valid/ready handshake and discards in-flight fetches on a taken branch or jump resolved in EX.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifb_queue.sv | 60 ++++++
 rtl/ifetch_prefetch_buffer.sv | 91 +++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
package ifetch_pkg;

   localparam logic [31:0] INITIAL_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        filled;
   } ifb_entry_t;

endpackage

// File: rtl/ifb_queue.sv
// In-order ring of fetch entries: allocated at request time, filled in order
// as IROM responses arrive, popped from the head by ID.
module ifb_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       alloc_i,
   input  logic [31:0]                alloc_pc_i,
   input  logic                       fill_i,
   input  logic [31:0]                fill_instr_i,
   input  logic                       pop_i,
   output ifb_entry_t                 head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   ifb_entry_t    entries_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [PW-1:0] fill_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc_i) tail_q <= tail_q + PW'(1);
         if (fill_i)  fill_q <= fill_q + PW'(1);
         if (pop_i)   head_q <= head_q + PW'(1);
         count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
      end
   end

   // Alloc, fill and pop never target the same slot in one cycle, so the
   // payload needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         if (alloc_i) begin
            entries_q[tail_q] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
         end
         if (fill_i) begin
            entries_q[fill_q].instr  <= fill_instr_i;
            entries_q[fill_q].filled <= 1'b1;
         end
      end
   end

   assign head_o  = entries_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Fetch front end: owns the fetch PC, issues IROM word requests and feeds
// ID from an in-order prefetch queue, discarding stale fetches on redirect.
module ifetch_prefetch_buffer
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = INITIAL_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        irom_req_o,
   output logic [13:0] irom_addr_o,
   input  logic        irom_gnt_i,
   input  logic        irom_rvalid_i,
   input  logic [31:0] irom_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc4_o,
   output logic [31:0] if_instr_o,
   input  logic        id_ready_i
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occupancy;
   logic [CW:0]   credit;
   logic          grant, resp, drop, fill, pop;
   ifb_entry_t    head;
   logic          unused_bits;

   // Unfilled entries are already tracked by outstanding, so the credit is
   // every allocated entry plus stale fetches still in flight.
   assign credit     = {1'b0, occupancy} + {1'b0, drop_cnt_q};
   assign irom_req_o = !rst && (credit < (CW+1)'(DEPTH));
   assign irom_addr_o = fetch_pc_q[15:2];

   assign grant = irom_req_o && irom_gnt_i;
   assign resp  = irom_rvalid_i && (outstanding_q != '0);
   assign drop  = resp && (drop_cnt_q != '0);
   assign fill  = resp && !drop && !redirect_i;
   assign pop   = if_valid_o && id_ready_i;

   assign outstanding_d = outstanding_q + CW'(grant) - CW'(resp);

   always_comb begin
      drop_cnt_d = drop_cnt_q - CW'(drop);
      fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      if (redirect_i) begin
         drop_cnt_d = outstanding_d;
         fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   ifb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect_i),
      .alloc_i      (grant),
      .alloc_pc_i   (fetch_pc_q),
      .fill_i       (fill),
      .fill_instr_i (irom_rdata_i),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (occupancy)
   );

   assign if_valid_o = (occupancy != '0) && head.filled;
   assign if_pc_o    = if_valid_o ? head.pc : 32'h0;
   assign if_pc4_o   = if_valid_o ? head.pc + 32'd4 : 32'd4;
   assign if_instr_o = if_valid_o ? head.instr : NOP_INSTR;

   assign unused_bits = ^{redirect_pc_i[1:0], fetch_pc_q[31:16], fetch_pc_q[1:0]};

endmodule
